// File: rtl/multibyte_add_seq_pkg.sv
// Shared definitions for the byte-serial wide adder sequencer.
package multibyte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the byte index register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple adder that sits beside the sequencer in the parent.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// Feeds one byte pair per cycle into an external 8-bit adder, chains the carry
// across cycles and returns the assembled wide sum through a valid/ready handshake.
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTE_W*NBYTES-1:0]   op_a,
    input  logic [BYTE_W*NBYTES-1:0]   op_b,
    input  logic                       op_cin,
    output logic [BYTE_W-1:0]          add_a,
    output logic [BYTE_W-1:0]          add_b,
    output logic                       add_cin,
    input  logic [BYTE_W-1:0]          add_sum,
    input  logic                       add_cout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [BYTE_W*NBYTES-1:0]   res_sum,
    output logic                       res_cout,
    output logic                       res_ovf
);

    localparam int                IDX_W    = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t                          state_r;
    state_t                          state_s;
    logic [NBYTES-1:0][BYTE_W-1:0]   a_r;
    logic [NBYTES-1:0][BYTE_W-1:0]   b_r;
    logic [NBYTES-1:0][BYTE_W-1:0]   sum_r;
    logic [IDX_W-1:0]                idx_r;
    logic                            carry_r;
    logic                            cout_r;
    logic                            ovf_r;
    logic                            last_s;

    assign last_s    = (idx_r == LAST_IDX);
    assign in_ready  = (state_r == ST_IDLE);
    assign res_valid = (state_r == ST_DONE);
    assign res_sum   = sum_r;
    assign res_cout  = cout_r;
    assign res_ovf   = ovf_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Adder inputs come only from latched operands so the adder never sees op_a/op_b directly.
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state_r == ST_RUN) begin
            add_a   = a_r[idx_r];
            add_b   = b_r[idx_r];
            add_cin = carry_r;
        end else begin
            add_a   = 8'd0;
            add_b   = 8'd0;
            add_cin = 1'b0;
        end
    end

    // Operand latch, byte collection and carry chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            idx_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= op_a;
                        b_r     <= op_b;
                        carry_r <= op_cin;
                        idx_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r] <= add_sum;
                    carry_r      <= add_cout;
                    if (last_s) begin
                        cout_r <= add_cout;
                        ovf_r  <= (a_r[LAST_IDX][BYTE_W-1] == b_r[LAST_IDX][BYTE_W-1]) &&
                                  (add_sum[BYTE_W-1] != a_r[LAST_IDX][BYTE_W-1]);
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench: sequencer plus adder_8bit, table vectors and corner sequences.
module tb_multibyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    logic          res_ovf;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_ovf  (res_ovf)
    );

    adder_8bit u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] cap_a[NB];
    logic [7:0] cap_b[NB];
    logic       cap_c[NB];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: compare on handshake, check stability while backpressured.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected res_valid", 32'(res_valid), 32'd0);
            end else if (res_ready) begin
                mon_e = sb.pop_front();
                check("res_sum", res_sum, mon_e.sum);
                check("res_cout", 32'(res_cout), 32'(mon_e.cout));
                check("res_ovf", 32'(res_ovf), 32'(mon_e.ovf));
                check("in_ready in DONE", 32'(in_ready), 32'd0);
            end else begin
                check("held res_sum", res_sum, sb[0].sum);
                check("held res_cout", 32'(res_cout), 32'(sb[0].cout));
            end
        end
    end

    // Drive a request and return #1 after the accept edge (first RUN cycle).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input bit push, input exp_t e);
        bit   accepted;
        logic rdy;
        accepted = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) accepted = 1'b1;
        end
        if (push && accepted) sb.push_back(e);
        #1;
        in_valid = 1'b0;
        if (!accepted) check("accept timeout", 32'd0, 32'd1);
    endtask

    // Count clocks until res_valid, capturing the adder bytes seen in RUN.
    task automatic wait_result(output int cnt);
        bit got;
        cap_a[0] = add_a;
        cap_b[0] = add_b;
        cap_c[0] = add_cin;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            @(posedge clk);
            cnt = cnt + 1;
            #1;
            if (res_valid) begin
                got = 1'b1;
            end else if (cnt < NB) begin
                cap_a[cnt] = add_a;
                cap_b[cnt] = add_b;
                cap_c[cnt] = add_cin;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        exp_t       e;
        int         cnt;
        logic       c;
        logic [8:0] part;
        e.sum  = v.sum;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        start_op(v.a, v.b, v.cin, 1'b1, e);
        wait_result(cnt);
        check($sformatf("latency vec%0d", n), 32'(cnt), 32'(NB));
        c = v.cin;
        for (int k = 0; k < NB; k++) begin
            check($sformatf("add_a vec%0d byte%0d", n, k), 32'(cap_a[k]), 32'(v.a[8*k +: 8]));
            check($sformatf("add_b vec%0d byte%0d", n, k), 32'(cap_b[k]), 32'(v.b[8*k +: 8]));
            check($sformatf("add_cin vec%0d byte%0d", n, k), 32'(cap_c[k]), 32'(c));
            part = {1'b0, v.a[8*k +: 8]} + {1'b0, v.b[8*k +: 8]} + {8'd0, c};
            c    = part[8];
        end
        @(posedge clk);
        #1;
        check($sformatf("add_a idle vec%0d", n), 32'(add_a), 32'd0);
        check($sformatf("res_valid cleared vec%0d", n), 32'(res_valid), 32'd0);
    endtask

    vec_t vecs[7];
    exp_t e_tmp;
    int   lat;

    initial begin
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h81818181, 32'h81818181, 1'b0, 32'h03030302, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset add_a", 32'(add_a), 32'd0);
        check("reset add_b", 32'(add_b), 32'd0);
        check("reset add_cin", 32'(add_cin), 32'd0);
        check("reset res_sum", res_sum, 32'd0);
        check("reset res_cout", 32'(res_cout), 32'd0);
        check("reset res_ovf", 32'(res_ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure in DONE with a request held that must not be taken early.
        res_ready = 1'b0;
        start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, model(32'h000000FF, 32'h00000001, 1'b0));
        in_valid = 1'b1;
        op_a     = 32'h00000001;
        op_b     = 32'h00000000;
        op_cin   = 1'b0;
        wait_result(lat);
        check("latency backpressure", 32'(lat), 32'(NB));
        for (int k = 0; k < 3; k++) begin
            check("bp res_valid", 32'(res_valid), 32'd1);
            check("bp res_sum", res_sum, 32'h00000100);
            check("bp in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        sb.push_back(model(32'h00000001, 32'h00000000, 1'b0));
        @(posedge clk);
        #1;
        check("release res_valid", 32'(res_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("late accept in_ready", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("latency late accept", 32'(lat), 32'(NB));
        @(posedge clk);
        #1;

        // Asynchronous reset two cycles into RUN.
        e_tmp = model(32'h11111111, 32'h22222222, 1'b0);
        start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0, e_tmp);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst res_valid", 32'(res_valid), 32'd0);
        check("async rst add_a", 32'(add_a), 32'd0);
        check("async rst add_b", 32'(add_b), 32'd0);
        check("async rst add_cin", 32'(add_cin), 32'd0);
        check("async rst res_sum", res_sum, 32'd0);
        check("async rst res_cout", 32'(res_cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no result after rst", 32'(res_valid), 32'd0);
        start_op(32'd2, 32'd3, 1'b0, 1'b1, model(32'd2, 32'd3, 1'b0));
        wait_result(lat);
        check("latency after rst", 32'(lat), 32'(NB));
        check("sum after rst", res_sum, 32'd5);
        @(posedge clk);
        #1;

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
Sequencer that adds two NBYTES-wide operands using one external 8-bit ripple adder (adder_8bit: a, b, cin -> sum, cout). It sits directly upstream of the adder and drives one byte pair per cycle. It also consumes the adder's sum/cout and chains the carry across cycles. The assembled wide result is returned through a valid/ready handshake.

Parameters:
NBYTES, 4, number of operand bytes; legal range is >= 1; result width is 8*NBYTES.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
op_a  input  8*NBYTES  operand A
op_b  input  8*NBYTES  operand B
op_cin  input  1  initial carry-in
add_a  output  8  byte of A to adder_8bit.a
add_b  output  8  byte of B to adder_8bit.b
add_cin  output  1  carry to adder_8bit.cin
add_sum  input  8  adder_8bit.sum, combinational, same cycle
add_cout  input  1  adder_8bit.cout, combinational, same cycle
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_sum  output  8*NBYTES  wide sum
res_cout  output  1  carry out of the MSB byte
res_ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- On reset:
  - state = IDLE, byte index = 0, carry register = 0.
  - Latched operands = 0.
  - res_sum, res_cout, res_ovf and res_valid = 0; in_ready = 1.
  - add_a, add_b and add_cin = 0.
- States:
  - IDLE: in_ready = 1. Accept when in_valid & in_ready. On accept, latch op_a/op_b, set carry = op_cin and idx = 0, then go to RUN.
  - RUN: in_ready = 0. The adder inputs are driven from registers only:
    - add_a = a_reg[8*idx +: 8]
    - add_b = b_reg[8*idx +: 8]
    - add_cin = carry
  - RUN, each clock edge: res_sum[8*idx +: 8] <= add_sum and carry <= add_cout.
    - If idx == NBYTES-1: res_cout <= add_cout, compute res_ovf, go to DONE.
    - Otherwise: idx <= idx+1.
  - DONE: res_valid = 1. res_sum, res_cout and res_ovf are held stable while res_ready = 0. When res_ready = 1, go to IDLE and clear res_valid.
- Outside RUN, add_a, add_b and add_cin = 0.
- Latency:
  - Accept edge to first RUN cycle: 1 clock.
  - RUN lasts exactly NBYTES cycles; res_valid rises NBYTES clocks after the accept edge.
  - Throughput: one operation per NBYTES+2 cycles when res_ready is held at 1.
- res_ovf = (a_reg MSB == b_reg MSB) & (add_sum[7] != a_reg MSB), evaluated on the final byte.
- res_sum bytes not yet written during RUN keep their previous-operation value. They are only guaranteed valid while res_valid = 1.
- Index register width: max(1, clog2(NBYTES)). NBYTES = 1 goes IDLE -> RUN (1 cycle) -> DONE.
- in_valid while not in IDLE: ignored, not queued.
- in_valid and res_ready both high in DONE: only the result is consumed. The new request is accepted in IDLE on the next cycle.
- Reset mid-RUN or mid-DONE: the operation is aborted, all outputs go to their reset values immediately, and no res_valid pulse is produced.
- Carry wrap: res_cout captures the final carry; there is no modulo error.

Decomposition:
- Shared package holds:
  - BYTE_W = 8
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - index-width function clog2
- No sub-module inside this block. adder_8bit is instantiated beside it in the parent, with add_* wired to a/b/cin/sum/cout.
- The bench instantiates both.

Test Plan:
1. NBYTES=4, A=0x000000FF, B=0x00000001, cin=0, res_ready=1 -> res_sum=0x00000100, res_cout=0, res_ovf=0. res_valid is high exactly 4 clocks after the accept edge. add_a sequence is FF, 00, 00, 00.
2. A=0xFFFFFFFF, B=0x00000001, cin=0 -> res_sum=0x00000000, res_cout=1, res_ovf=0.
3. A=0x7FFFFFFF, B=0x00000001 -> res_sum=0x80000000, res_cout=0, res_ovf=1. A=0x81818181, B=0x81818181 -> res_sum=0x03030302, res_cout=1, res_ovf=1.
4. A=0x12345678, B=0x11111111, cin=1 -> res_sum=0x2345678A, res_cout=0. add_cin=1 in the first RUN cycle only.
5. Backpressure, using test 1 operands:
   - Hold res_ready=0 for 3 cycles in DONE -> res_valid and res_sum held at 0x00000100, in_ready=0.
   - in_valid pulsed with A=0x1 during RUN/DONE -> ignored.
   - Release res_ready -> IDLE next cycle.
6. Assert rst asynchronously after 2 RUN cycles -> outputs go to zero and in_ready=1 without a clock edge. No res_valid follows. A new accept afterwards completes correctly (A=2, B=3 -> 5).
